// File: rtl/axil_master_bridge_pkg.sv
// Shared definitions for the AXI4-Lite master bridge: memory operation codes,
// FSM states, AXI response codes and request decode helpers.
package axil_master_bridge_pkg;

    localparam logic [2:0] MEM_LB  = 3'd0;
    localparam logic [2:0] MEM_LBU = 3'd1;
    localparam logic [2:0] MEM_LH  = 3'd2;
    localparam logic [2:0] MEM_LHU = 3'd3;
    localparam logic [2:0] MEM_LW  = 3'd4;
    localparam logic [2:0] MEM_SB  = 3'd5;
    localparam logic [2:0] MEM_SH  = 3'd6;
    localparam logic [2:0] MEM_SW  = 3'd7;

    localparam logic [1:0] RespOkay   = 2'b00;
    localparam logic [1:0] RespSlverr = 2'b10;

    typedef enum logic [2:0] {
        StBosta,
        StOkuAdres,
        StOkuVeri,
        StYaz,
        StYazYanit,
        StHata
    } durum_e;

    function automatic logic op_is_load(input logic [2:0] op);
        return op inside {MEM_LB, MEM_LBU, MEM_LH, MEM_LHU, MEM_LW};
    endfunction

    function automatic logic op_is_store(input logic [2:0] op);
        return op inside {MEM_SB, MEM_SH, MEM_SW};
    endfunction

    function automatic logic op_misaligned(input logic [2:0] op, input logic [1:0] addr_lo);
        case (op)
            MEM_LH, MEM_LHU, MEM_SH: return addr_lo[0];
            MEM_LW, MEM_SW:          return addr_lo != 2'b00;
            default:                 return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/axil_lane_format.sv
// Combinational byte-lane steering: store data/strobe placement on the bus and
// load lane extraction with sign or zero extension.
module axil_lane_format
    import axil_master_bridge_pkg::*;
#(
    parameter int unsigned DATA_W = 32
) (
    input  logic [2:0]                  st_op_i,
    input  logic [$clog2(DATA_W/8)-1:0] st_off_i,
    input  logic [31:0]                 st_data_i,
    output logic [DATA_W-1:0]           st_wdata_o,
    output logic [DATA_W/8-1:0]         st_wstrb_o,
    input  logic [2:0]                  ld_op_i,
    input  logic [$clog2(DATA_W/8)-1:0] ld_off_i,
    input  logic [DATA_W-1:0]           ld_rdata_i,
    output logic [31:0]                 ld_data_o
);
    localparam int unsigned STRB_W = DATA_W / 8;

    logic [STRB_W-1:0] strb_base;
    logic [31:0]       lane;

    // The operand lane is repeated across the whole bus, so every aligned offset
    // already carries the data; shifting by off*8 leaves the pattern unchanged.
    always_comb begin
        st_wdata_o = '0;
        strb_base  = '0;
        case (st_op_i)
            MEM_SB: begin
                st_wdata_o = {(DATA_W/8){st_data_i[7:0]}};
                strb_base  = STRB_W'(4'b0001);
            end
            MEM_SH: begin
                st_wdata_o = {(DATA_W/16){st_data_i[15:0]}};
                strb_base  = STRB_W'(4'b0011);
            end
            MEM_SW: begin
                st_wdata_o = {(DATA_W/32){st_data_i}};
                strb_base  = STRB_W'(4'b1111);
            end
            default: ;
        endcase
        st_wstrb_o = strb_base << st_off_i;
    end

    always_comb begin
        lane = 32'(ld_rdata_i >> {ld_off_i, 3'b000});
        case (ld_op_i)
            MEM_LB:  ld_data_o = {{24{lane[7]}}, lane[7:0]};
            MEM_LBU: ld_data_o = {24'h0, lane[7:0]};
            MEM_LH:  ld_data_o = {{16{lane[15]}}, lane[15:0]};
            MEM_LHU: ld_data_o = {16'h0, lane[15:0]};
            MEM_LW:  ld_data_o = lane;
            default: ld_data_o = '0;
        endcase
    end

endmodule

// File: rtl/axil_master_bridge.sv
// AXI4-Lite master turning one load/store request into a single bus transaction,
// one outstanding at a time, with registered bus and response outputs.
module axil_master_bridge
    import axil_master_bridge_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic                axi_aclk_i,
    input  logic                axi_aresetn_i,
    input  logic                istek_gecerli_i,
    output logic                istek_hazir_o,
    input  logic [2:0]          buyruk_turu_i,
    input  logic [ADDR_W-1:0]   address_i,
    input  logic [31:0]         data_i,
    output logic                yanit_gecerli_o,
    output logic [31:0]         okunan_veri_o,
    output logic                yanit_hata_o,
    output logic [1:0]          yanit_resp_o,
    output logic [ADDR_W-1:0]   axi_araddr_o,
    output logic                axi_arvalid_o,
    input  logic                axi_arready_i,
    output logic [2:0]          axi_arprot_o,
    input  logic [DATA_W-1:0]   axi_rdata_i,
    input  logic [1:0]          axi_rresp_i,
    input  logic                axi_rvalid_i,
    output logic                axi_rready_o,
    output logic [ADDR_W-1:0]   axi_awaddr_o,
    output logic                axi_awvalid_o,
    input  logic                axi_awready_i,
    output logic [2:0]          axi_awprot_o,
    output logic [DATA_W-1:0]   axi_wdata_o,
    output logic [DATA_W/8-1:0] axi_wstrb_o,
    output logic                axi_wvalid_o,
    input  logic                axi_wready_i,
    input  logic [1:0]          axi_bresp_i,
    input  logic                axi_bvalid_i,
    output logic                axi_bready_o
);
    localparam int unsigned STRB_W = DATA_W / 8;
    localparam int unsigned OFF_W  = $clog2(STRB_W);

    durum_e              state_q, state_d;
    logic [2:0]          op_q, op_d;
    logic [OFF_W-1:0]    off_q, off_d;
    logic [ADDR_W-1:0]   araddr_q, araddr_d;
    logic                arvalid_q, arvalid_d;
    logic                rready_q, rready_d;
    logic [ADDR_W-1:0]   awaddr_q, awaddr_d;
    logic                awvalid_q, awvalid_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [STRB_W-1:0]   wstrb_q, wstrb_d;
    logic                wvalid_q, wvalid_d;
    logic                bready_q, bready_d;
    logic                yanit_gecerli_q, yanit_gecerli_d;
    logic [31:0]         okunan_veri_q, okunan_veri_d;
    logic                yanit_hata_q, yanit_hata_d;
    logic [1:0]          yanit_resp_q, yanit_resp_d;

    logic [ADDR_W-1:0]   bus_addr;
    logic [DATA_W-1:0]   fmt_wdata;
    logic [STRB_W-1:0]   fmt_wstrb;
    logic [31:0]         fmt_load;
    logic                aw_ok, w_ok;

    axil_lane_format #(
        .DATA_W(DATA_W)
    ) u_lane_format (
        .st_op_i   (buyruk_turu_i),
        .st_off_i  (address_i[OFF_W-1:0]),
        .st_data_i (data_i),
        .st_wdata_o(fmt_wdata),
        .st_wstrb_o(fmt_wstrb),
        .ld_op_i   (op_q),
        .ld_off_i  (off_q),
        .ld_rdata_i(axi_rdata_i),
        .ld_data_o (fmt_load)
    );

    always_comb begin
        bus_addr              = address_i;
        bus_addr[OFF_W-1:0]   = '0;
    end

    always_comb begin
        state_d         = state_q;
        op_d            = op_q;
        off_d           = off_q;
        araddr_d        = araddr_q;
        arvalid_d       = arvalid_q;
        rready_d        = rready_q;
        awaddr_d        = awaddr_q;
        awvalid_d       = awvalid_q;
        wdata_d         = wdata_q;
        wstrb_d         = wstrb_q;
        wvalid_d        = wvalid_q;
        bready_d        = bready_q;
        yanit_gecerli_d = 1'b0;
        okunan_veri_d   = okunan_veri_q;
        yanit_hata_d    = yanit_hata_q;
        yanit_resp_d    = yanit_resp_q;
        aw_ok           = 1'b0;
        w_ok            = 1'b0;

        case (state_q)
            StBosta: begin
                if (istek_gecerli_i) begin
                    op_d  = buyruk_turu_i;
                    off_d = address_i[OFF_W-1:0];
                    if (op_misaligned(buyruk_turu_i, address_i[1:0]) ||
                        !(op_is_load(buyruk_turu_i) || op_is_store(buyruk_turu_i))) begin
                        state_d = StHata;
                    end else if (op_is_load(buyruk_turu_i)) begin
                        state_d   = StOkuAdres;
                        araddr_d  = bus_addr;
                        arvalid_d = 1'b1;
                    end else begin
                        state_d   = StYaz;
                        awaddr_d  = bus_addr;
                        awvalid_d = 1'b1;
                        wdata_d   = fmt_wdata;
                        wstrb_d   = fmt_wstrb;
                        wvalid_d  = 1'b1;
                    end
                end
            end
            StOkuAdres: begin
                if (axi_arready_i) begin
                    state_d   = StOkuVeri;
                    araddr_d  = '0;
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                end
            end
            StOkuVeri: begin
                if (axi_rvalid_i) begin
                    state_d         = StBosta;
                    rready_d        = 1'b0;
                    yanit_gecerli_d = 1'b1;
                    yanit_resp_d    = axi_rresp_i;
                    yanit_hata_d    = axi_rresp_i != RespOkay;
                    okunan_veri_d   = (axi_rresp_i == RespOkay) ? fmt_load : 32'h0;
                end
            end
            StYaz: begin
                // A channel already handshaken earlier counts as done.
                aw_ok = !awvalid_q || axi_awready_i;
                w_ok  = !wvalid_q || axi_wready_i;
                if (awvalid_q && axi_awready_i) begin
                    awvalid_d = 1'b0;
                    awaddr_d  = '0;
                end
                if (wvalid_q && axi_wready_i) begin
                    wvalid_d = 1'b0;
                    wdata_d  = '0;
                    wstrb_d  = '0;
                end
                if (aw_ok && w_ok) begin
                    state_d  = StYazYanit;
                    bready_d = 1'b1;
                end
            end
            StYazYanit: begin
                if (axi_bvalid_i) begin
                    state_d         = StBosta;
                    bready_d        = 1'b0;
                    yanit_gecerli_d = 1'b1;
                    yanit_resp_d    = axi_bresp_i;
                    yanit_hata_d    = axi_bresp_i != RespOkay;
                    okunan_veri_d   = 32'h0;
                end
            end
            StHata: begin
                state_d         = StBosta;
                yanit_gecerli_d = 1'b1;
                yanit_resp_d    = RespSlverr;
                yanit_hata_d    = 1'b1;
                okunan_veri_d   = 32'h0;
            end
            default: state_d = StBosta;
        endcase
    end

    always_ff @(posedge axi_aclk_i) begin
        if (!axi_aresetn_i) begin
            state_q         <= StBosta;
            op_q            <= '0;
            off_q           <= '0;
            araddr_q        <= '0;
            arvalid_q       <= 1'b0;
            rready_q        <= 1'b0;
            awaddr_q        <= '0;
            awvalid_q       <= 1'b0;
            wdata_q         <= '0;
            wstrb_q         <= '0;
            wvalid_q        <= 1'b0;
            bready_q        <= 1'b0;
            yanit_gecerli_q <= 1'b0;
            okunan_veri_q   <= '0;
            yanit_hata_q    <= 1'b0;
            yanit_resp_q    <= '0;
        end else begin
            state_q         <= state_d;
            op_q            <= op_d;
            off_q           <= off_d;
            araddr_q        <= araddr_d;
            arvalid_q       <= arvalid_d;
            rready_q        <= rready_d;
            awaddr_q        <= awaddr_d;
            awvalid_q       <= awvalid_d;
            wdata_q         <= wdata_d;
            wstrb_q         <= wstrb_d;
            wvalid_q        <= wvalid_d;
            bready_q        <= bready_d;
            yanit_gecerli_q <= yanit_gecerli_d;
            okunan_veri_q   <= okunan_veri_d;
            yanit_hata_q    <= yanit_hata_d;
            yanit_resp_q    <= yanit_resp_d;
        end
    end

    assign istek_hazir_o   = state_q == StBosta;
    assign yanit_gecerli_o = yanit_gecerli_q;
    assign okunan_veri_o   = okunan_veri_q;
    assign yanit_hata_o    = yanit_hata_q;
    assign yanit_resp_o    = yanit_resp_q;
    assign axi_araddr_o    = araddr_q;
    assign axi_arvalid_o   = arvalid_q;
    assign axi_arprot_o    = 3'b000;
    assign axi_rready_o    = rready_q;
    assign axi_awaddr_o    = awaddr_q;
    assign axi_awvalid_o   = awvalid_q;
    assign axi_awprot_o    = 3'b000;
    assign axi_wdata_o     = wdata_q;
    assign axi_wstrb_o     = wstrb_q;
    assign axi_wvalid_o    = wvalid_q;
    assign axi_bready_o    = bready_q;

endmodule

// File: tb/tb_axil_master_bridge.sv
// Self-checking bench for axil_master_bridge with a configurable AXI4-Lite slave
// and a scoreboard of expected responses.
module tb_axil_master_bridge;
    import axil_master_bridge_pkg::*;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        istek_gecerli = 1'b0;
    logic        istek_hazir;
    logic [2:0]  buyruk = '0;
    logic [31:0] address = '0;
    logic [31:0] data = '0;
    logic        yanit_gecerli;
    logic [31:0] okunan_veri;
    logic        yanit_hata;
    logic [1:0]  yanit_resp;
    logic [31:0] araddr, awaddr, wdata;
    logic        arvalid, awvalid, wvalid, rready, bready;
    logic        arready = 1'b0, awready = 1'b0, wready = 1'b0, rvalid = 1'b0, bvalid = 1'b0;
    logic [2:0]  arprot, awprot;
    logic [31:0] rdata = '0;
    logic [1:0]  rresp = '0, bresp = '0;
    logic [3:0]  wstrb;

    always #5 clk = ~clk;

    axil_master_bridge #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W)
    ) dut (
        .axi_aclk_i     (clk),
        .axi_aresetn_i  (rstn),
        .istek_gecerli_i(istek_gecerli),
        .istek_hazir_o  (istek_hazir),
        .buyruk_turu_i  (buyruk),
        .address_i      (address),
        .data_i         (data),
        .yanit_gecerli_o(yanit_gecerli),
        .okunan_veri_o  (okunan_veri),
        .yanit_hata_o   (yanit_hata),
        .yanit_resp_o   (yanit_resp),
        .axi_araddr_o   (araddr),
        .axi_arvalid_o  (arvalid),
        .axi_arready_i  (arready),
        .axi_arprot_o   (arprot),
        .axi_rdata_i    (rdata),
        .axi_rresp_i    (rresp),
        .axi_rvalid_i   (rvalid),
        .axi_rready_o   (rready),
        .axi_awaddr_o   (awaddr),
        .axi_awvalid_o  (awvalid),
        .axi_awready_i  (awready),
        .axi_awprot_o   (awprot),
        .axi_wdata_o    (wdata),
        .axi_wstrb_o    (wstrb),
        .axi_wvalid_o   (wvalid),
        .axi_wready_i   (wready),
        .axi_bresp_i    (bresp),
        .axi_bvalid_i   (bvalid),
        .axi_bready_o   (bready)
    );

    typedef struct packed {
        logic [31:0] data;
        logic        hata;
        logic [1:0]  resp;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_mis = 0;

    // Slave configuration and activity counters
    int          ar_delay = 0, aw_delay = 0, w_delay = 0;
    logic [31:0] slv_rdata = '0;
    logic [1:0]  slv_rresp = RespOkay, slv_bresp = RespOkay;
    int          ar_seen = 0, aw_seen = 0, b_count = 0;
    int          ar_cnt = 0, aw_cnt = 0, w_cnt = 0;
    logic        ar_hs = 1'b0, r_hs = 1'b0, aw_hs = 1'b0, w_hs = 1'b0, b_hs = 1'b0;
    logic        aw_got = 1'b0, w_got = 1'b0;

    always @(negedge clk) begin
        if (!rstn) begin
            arready = 0; awready = 0; wready = 0; rvalid = 0; bvalid = 0;
            ar_cnt = 0; aw_cnt = 0; w_cnt = 0; aw_got = 0; w_got = 0;
        end else begin
            if (r_hs) rvalid = 0;
            if (b_hs) begin bvalid = 0; b_count++; end
            if (ar_hs) begin rvalid = 1; rdata = slv_rdata; rresp = slv_rresp; end
            if (aw_hs) aw_got = 1;
            if (w_hs) w_got = 1;
            if (aw_got && w_got) begin aw_got = 0; w_got = 0; bvalid = 1; bresp = slv_bresp; end
            if (arvalid) begin ar_seen++; arready = ar_cnt >= ar_delay; ar_cnt++; end
            else begin arready = 0; ar_cnt = 0; end
            if (awvalid) begin aw_seen++; awready = aw_cnt >= aw_delay; aw_cnt++; end
            else begin awready = 0; aw_cnt = 0; end
            if (wvalid) begin wready = w_cnt >= w_delay; w_cnt++; end
            else begin wready = 0; w_cnt = 0; end
        end
        ar_hs = arvalid && arready;
        r_hs  = rvalid && rready;
        aw_hs = awvalid && awready;
        w_hs  = wvalid && wready;
        b_hs  = bvalid && bready;
    end

    task automatic send(input logic [2:0] op, input logic [31:0] a, input logic [31:0] d);
        istek_gecerli = 1; buyruk = op; address = a; data = d;
        @(negedge clk);
        istek_gecerli = 0;
    endtask

    task automatic wait_resp(input int start, input int budget, output int lat);
        lat = -1;
        for (int c = start; c < start + budget && lat < 0; c++) begin
            if (yanit_gecerli) lat = c;
            else @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rstn = 0;
        repeat (3) @(negedge clk);
        rstn = 1;
        @(negedge clk);
        n_cmp++; if (istek_hazir !== 1'b1) begin n_mis++; $display("FAIL reset_hazir: got %b want 1", istek_hazir); end
        n_cmp++; if ({arvalid, awvalid, wvalid} !== 3'b000) begin n_mis++; $display("FAIL reset_valids: got %b want 000", {arvalid, awvalid, wvalid}); end
        n_cmp++; if ({rready, bready, yanit_gecerli} !== 3'b000) begin n_mis++; $display("FAIL reset_ready_resp: got %b want 000", {rready, bready, yanit_gecerli}); end
        n_cmp++; if ({araddr, awaddr, wdata, wstrb} !== 100'h0) begin n_mis++; $display("FAIL reset_bus_zero: got %h", {araddr, awaddr, wdata, wstrb}); end
        n_cmp++; if ({arprot, awprot} !== 6'b0) begin n_mis++; $display("FAIL reset_prot: got %b want 0", {arprot, awprot}); end
    endtask

    task automatic test_lw();
        int   lat;
        exp_t e;
        slv_rdata = 32'hDEADBEEF; slv_rresp = RespOkay;
        sb.push_back('{data: 32'hDEADBEEF, hata: 1'b0, resp: RespOkay});
        send(MEM_LW, 32'h1000, 32'h0);
        n_cmp++; if ({arvalid, araddr} !== {1'b1, 32'h1000}) begin n_mis++; $display("FAIL lw_ar: got v=%b a=%h want v=1 a=00001000", arvalid, araddr); end
        wait_resp(1, 20, lat);
        n_cmp++; if (lat !== 3) begin n_mis++; $display("FAIL lw_latency: got %0d want 3", lat); end
        e = sb.pop_front();
        n_cmp++; if (okunan_veri !== e.data) begin n_mis++; $display("FAIL lw_data: got %h want %h", okunan_veri, e.data); end
        n_cmp++; if ({yanit_hata, yanit_resp} !== {e.hata, e.resp}) begin n_mis++; $display("FAIL lw_status: got %b want %b", {yanit_hata, yanit_resp}, {e.hata, e.resp}); end
        n_cmp++; if (araddr !== 32'h0) begin n_mis++; $display("FAIL lw_araddr_idle: got %h want 0", araddr); end
    endtask

    localparam logic [2:0]  LD_OP  [6] = '{MEM_LB, MEM_LBU, MEM_LH, MEM_LHU, MEM_LB, MEM_LBU};
    localparam logic [31:0] LD_A   [6] = '{32'h1003, 32'h1003, 32'h1002, 32'h1002, 32'h1001, 32'h1000};
    localparam logic [31:0] LD_RD  [6] = '{32'h80FFFFFF, 32'h80FFFFFF, 32'h80011234, 32'h80011234,
                                           32'h00007F00, 32'h000000C3};
    localparam logic [31:0] LD_EXP [6] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF8001, 32'h00008001,
                                           32'h0000007F, 32'h000000C3};

    task automatic test_load_lanes();
        int   lat;
        exp_t e;
        for (int i = 0; i < 6; i++) begin
            slv_rdata = LD_RD[i]; slv_rresp = RespOkay;
            sb.push_back('{data: LD_EXP[i], hata: 1'b0, resp: RespOkay});
            send(LD_OP[i], LD_A[i], 32'h0);
            n_cmp++; if (araddr !== 32'h1000) begin n_mis++; $display("FAIL load%0d_araddr: got %h want 00001000", i, araddr); end
            wait_resp(1, 20, lat);
            e = sb.pop_front();
            n_cmp++; if ({lat == 3, okunan_veri, yanit_hata} !== {1'b1, e.data, e.hata}) begin
                n_mis++; $display("FAIL load%0d: got lat=%0d d=%h h=%b want lat=3 d=%h h=%b", i, lat, okunan_veri, yanit_hata, e.data, e.hata);
            end
        end
    endtask

    task automatic test_sh_split();
        int   lat;
        int   b0;
        exp_t e;
        aw_delay = 1; w_delay = 4; slv_bresp = RespOkay;
        b0 = b_count;
        sb.push_back('{data: 32'h0, hata: 1'b0, resp: RespOkay});
        send(MEM_SH, 32'h1002, 32'h0000ABCD);
        n_cmp++; if ({awvalid, wvalid, awaddr} !== {2'b11, 32'h1000}) begin n_mis++; $display("FAIL sh_aw: got v=%b%b a=%h want 11 00001000", awvalid, wvalid, awaddr); end
        n_cmp++; if ({wdata, wstrb} !== {32'hABCDABCD, 4'b1100}) begin n_mis++; $display("FAIL sh_w: got d=%h s=%b want abcdabcd 1100", wdata, wstrb); end
        repeat (2) @(negedge clk);
        n_cmp++; if ({awvalid, awaddr, wvalid, wdata} !== {1'b0, 32'h0, 1'b1, 32'hABCDABCD}) begin
            n_mis++; $display("FAIL sh_split_mid: got awv=%b awa=%h wv=%b wd=%h", awvalid, awaddr, wvalid, wdata);
        end
        wait_resp(3, 30, lat);
        n_cmp++; if (lat !== 7) begin n_mis++; $display("FAIL sh_latency: got %0d want 7", lat); end
        e = sb.pop_front();
        n_cmp++; if ({okunan_veri, yanit_hata, yanit_resp} !== {e.data, e.hata, e.resp}) begin n_mis++; $display("FAIL sh_resp: got %h %b %b", okunan_veri, yanit_hata, yanit_resp); end
        @(negedge clk);
        n_cmp++; if (b_count - b0 !== 1) begin n_mis++; $display("FAIL sh_b_count: got %0d want 1", b_count - b0); end
        aw_delay = 0; w_delay = 0;
    endtask

    localparam logic [2:0]  ST_OP   [3] = '{MEM_SB, MEM_SW, MEM_SB};
    localparam logic [31:0] ST_A    [3] = '{32'h1001, 32'h1004, 32'h1003};
    localparam logic [31:0] ST_D    [3] = '{32'h0000005A, 32'h01234567, 32'h123456EE};
    localparam logic [31:0] ST_WD   [3] = '{32'h5A5A5A5A, 32'h01234567, 32'hEEEEEEEE};
    localparam logic [3:0]  ST_WS   [3] = '{4'b0010, 4'b1111, 4'b1000};
    localparam logic [31:0] ST_AW   [3] = '{32'h1000, 32'h1004, 32'h1000};

    task automatic test_stores();
        int   lat;
        exp_t e;
        for (int i = 0; i < 3; i++) begin
            sb.push_back('{data: 32'h0, hata: 1'b0, resp: RespOkay});
            send(ST_OP[i], ST_A[i], ST_D[i]);
            n_cmp++; if ({awaddr, wdata, wstrb} !== {ST_AW[i], ST_WD[i], ST_WS[i]}) begin
                n_mis++; $display("FAIL store%0d_bus: got a=%h d=%h s=%b want a=%h d=%h s=%b", i, awaddr, wdata, wstrb, ST_AW[i], ST_WD[i], ST_WS[i]);
            end
            wait_resp(1, 20, lat);
            e = sb.pop_front();
            n_cmp++; if ({lat == 3, okunan_veri, yanit_hata, wdata, wstrb} !== {1'b1, e.data, e.hata, 32'h0, 4'h0}) begin
                n_mis++; $display("FAIL store%0d_resp: got lat=%0d d=%h h=%b wd=%h ws=%b", i, lat, okunan_veri, yanit_hata, wdata, wstrb);
            end
        end
    endtask

    localparam logic [2:0]  MA_OP [4] = '{MEM_LW, MEM_LH, MEM_SW, MEM_SH};
    localparam logic [31:0] MA_A  [4] = '{32'h1002, 32'h1001, 32'h1003, 32'h1005};

    task automatic test_misaligned();
        int   lat;
        int   ar0, aw0;
        exp_t e;
        for (int i = 0; i < 4; i++) begin
            ar0 = ar_seen; aw0 = aw_seen;
            sb.push_back('{data: 32'h0, hata: 1'b1, resp: RespSlverr});
            send(MA_OP[i], MA_A[i], 32'hFFFFFFFF);
            wait_resp(1, 20, lat);
            n_cmp++; if (lat !== 2) begin n_mis++; $display("FAIL misal%0d_latency: got %0d want 2", i, lat); end
            e = sb.pop_front();
            n_cmp++; if ({okunan_veri, yanit_hata, yanit_resp} !== {e.data, e.hata, e.resp}) begin
                n_mis++; $display("FAIL misal%0d_resp: got d=%h h=%b r=%b want d=%h h=%b r=%b", i, okunan_veri, yanit_hata, yanit_resp, e.data, e.hata, e.resp);
            end
            n_cmp++; if ({ar_seen - ar0, aw_seen - aw0} !== {32'd0, 32'd0}) begin n_mis++; $display("FAIL misal%0d_bus: ar=%0d aw=%0d want 0", i, ar_seen - ar0, aw_seen - aw0); end
        end
    endtask

    task automatic test_back_to_back();
        int   lat;
        exp_t e;
        slv_bresp = RespSlverr;
        sb.push_back('{data: 32'h0, hata: 1'b1, resp: RespSlverr});
        send(MEM_SW, 32'h2000, 32'h0000CAFE);
        wait_resp(1, 20, lat);
        e = sb.pop_front();
        n_cmp++; if ({lat == 3, okunan_veri, yanit_hata, yanit_resp} !== {1'b1, e.data, e.hata, e.resp}) begin
            n_mis++; $display("FAIL sw_slverr: got lat=%0d d=%h h=%b r=%b want lat=3 d=0 h=1 r=10", lat, okunan_veri, yanit_hata, yanit_resp);
        end
        n_cmp++; if (istek_hazir !== 1'b1) begin n_mis++; $display("FAIL b2b_hazir: got %b want 1", istek_hazir); end
        slv_bresp = RespOkay; slv_rdata = 32'h12345678; slv_rresp = RespOkay;
        sb.push_back('{data: 32'h12345678, hata: 1'b0, resp: RespOkay});
        send(MEM_LW, 32'h2000, 32'h0);
        n_cmp++; if (araddr !== 32'h2000) begin n_mis++; $display("FAIL b2b_araddr: got %h want 00002000", araddr); end
        wait_resp(1, 20, lat);
        e = sb.pop_front();
        n_cmp++; if ({lat == 3, okunan_veri, yanit_hata, yanit_resp} !== {1'b1, e.data, e.hata, e.resp}) begin
            n_mis++; $display("FAIL b2b_lw: got lat=%0d d=%h h=%b r=%b want lat=3 d=%h", lat, okunan_veri, yanit_hata, yanit_resp, e.data);
        end
        slv_rdata = 32'hFFFFFFFF; slv_rresp = RespSlverr;
        sb.push_back('{data: 32'h0, hata: 1'b1, resp: RespSlverr});
        send(MEM_LW, 32'h3000, 32'h0);
        wait_resp(1, 20, lat);
        e = sb.pop_front();
        n_cmp++; if ({lat == 3, okunan_veri, yanit_hata, yanit_resp} !== {1'b1, e.data, e.hata, e.resp}) begin
            n_mis++; $display("FAIL lw_rresp_err: got lat=%0d d=%h h=%b r=%b want lat=3 d=0 h=1 r=10", lat, okunan_veri, yanit_hata, yanit_resp);
        end
        slv_rresp = RespOkay;
    endtask

    task automatic test_reset_mid();
        int pulses = 0;
        ar_delay = 1000;
        send(MEM_LW, 32'h1000, 32'h0);
        @(negedge clk);
        n_cmp++; if ({arvalid, istek_hazir} !== 2'b10) begin n_mis++; $display("FAIL rst_mid_stall: got v=%b hz=%b want 1 0", arvalid, istek_hazir); end
        rstn = 0;
        @(negedge clk);
        n_cmp++; if ({arvalid, rready, istek_hazir, yanit_gecerli} !== 4'b0010) begin
            n_mis++; $display("FAIL rst_mid_after: got v=%b rr=%b hz=%b yg=%b want 0 0 1 0", arvalid, rready, istek_hazir, yanit_gecerli);
        end
        rstn = 1; ar_delay = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (yanit_gecerli) pulses++;
        end
        n_cmp++; if (pulses !== 0) begin n_mis++; $display("FAIL rst_mid_pulse: got %0d want 0", pulses); end
    endtask

    initial begin
        test_reset();
        test_lw();
        test_load_lanes();
        test_sh_split();
        test_stores();
        test_misaligned();
        test_back_to_back();
        test_reset_mid();
        n_cmp++; if (sb.size() !== 0) begin n_mis++; $display("FAIL scoreboard_drain: got %0d want 0", sb.size()); end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
